// File: rtl/ama_riscv_mem_responder.sv
// Single-port word memory responding on a valid/ready channel with a credit-protected response FIFO.
// Define MEM_RESP_WR_ACK_EN to have every accepted write return a zero-data response beat.
module ama_riscv_mem_responder #(
    parameter int unsigned DEPTH_W  = 16384,
    parameter int unsigned AW       = $clog2(DEPTH_W),
    parameter int unsigned LAT      = 1,
    parameter int unsigned RSP_FIFO = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_we,
    input  logic [3:0]    req_wmask,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          busy
);
    localparam int unsigned DW = 32;
    localparam int unsigned PW = (RSP_FIFO > 1) ? $clog2(RSP_FIFO) : 1;
    localparam int unsigned CW = $clog2(RSP_FIFO + 1);
`ifdef MEM_RESP_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    logic [DW-1:0] mem [DEPTH_W];

    logic          accept_c;
    logic          rsp_accept_c;
    logic          pop_c;
    logic          push_c;
    logic [DW-1:0] rsp_word_c;
    logic [DW-1:0] push_data_c;
    logic [DW-1:0] head_c;

    logic          pipe_valid_q, pipe_valid_d;
    logic [DW-1:0] pipe_data_q, pipe_data_d;
    logic [DW-1:0] fifo_q [RSP_FIFO];
    logic [DW-1:0] fifo_d [RSP_FIFO];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] pending_q, pending_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          busy_q, busy_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_FIFO - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshakes; writes only take a credit when they are acknowledged
    always_comb begin
        accept_c     = req_valid && req_ready_q;
        rsp_accept_c = accept_c && (!req_we || WR_ACK);
        pop_c        = rsp_valid_q && rsp_ready;
        rsp_word_c   = req_we ? '0 : mem[req_addr];
    end

    // Optional extra read stage for LAT=2; LAT=1 pushes straight into the FIFO
    always_comb begin
        pipe_valid_d = (LAT > 1) ? rsp_accept_c : 1'b0;
        pipe_data_d  = rsp_word_c;
        if (LAT > 1) begin
            push_c      = pipe_valid_q;
            push_data_c = pipe_data_q;
        end else begin
            push_c      = rsp_accept_c;
            push_data_c = rsp_word_c;
        end
    end

    // FIFO bookkeeping plus a registered copy of the head for the response port
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CW'(push_c) - CW'(pop_c);
        pending_d  = pending_q + CW'(rsp_accept_c) - CW'(pop_c);
        if (push_c) begin
            fifo_d[wr_ptr_q] = push_data_c;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // An entry pushed into an emptying FIFO falls through to the head
        if (fifo_cnt_q == CW'(pop_c)) begin
            head_c = push_data_c;
        end else begin
            head_c = fifo_q[rd_ptr_d];
        end
        rsp_valid_d = (fifo_cnt_d != '0);
        rsp_data_d  = rsp_valid_d ? head_c : rsp_data_q;
        req_ready_d = (pending_d < CW'(RSP_FIFO));
        busy_d      = (pending_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
            for (int i = 0; i < int'(RSP_FIFO); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            pending_q   <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            pending_q    <= pending_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            busy_q       <= busy_d;
        end
    end

    // Memory contents survive reset
    always_ff @(posedge clk) begin
        if (accept_c && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wmask[b]) begin
                    mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule
